// File: rtl/planning_pkg.sv
// Shared definitions for the grid planning block.
// Holds the move direction encoding, the one-hot request decode and the
// default grid dimensions.
package planning_pkg;

   localparam int DEF_GRID_W = 8;
   localparam int DEF_GRID_H = 8;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   // A request is only a move when exactly one bit is set; any other
   // combination (none, or conflicting bits) decodes to DIR_NONE.
   function automatic dir_e decode_dir(input logic up, input logic down,
                                       input logic left, input logic right);
      case ({up, down, left, right})
         4'b1000: decode_dir = DIR_UP;
         4'b0100: decode_dir = DIR_DOWN;
         4'b0010: decode_dir = DIR_LEFT;
         4'b0001: decode_dir = DIR_RIGHT;
         default: decode_dir = DIR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/planning_grid_mover.sv
// grid_mover: one object moving on the grid.
// Ports:
//   clk, rst_n            clock, async active-low reset (position -> X0,Y0)
//   en                    this mover may act on its request this cycle
//   up/down/left/right    move request (one-hot to be honoured)
//   nxt_x, nxt_y          combinational next position (clamped to the grid)
//   moved                 next position differs from the current one
module grid_mover
   import planning_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H,
   parameter int X0     = 0,
   parameter int Y0     = 0,
   parameter int XW     = (GRID_W > 1) ? $clog2(GRID_W) : 1,
   parameter int YW     = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          up,
   input  logic          down,
   input  logic          left,
   input  logic          right,
   output logic [XW-1:0] nxt_x,
   output logic [YW-1:0] nxt_y,
   output logic          moved
);

   logic [XW-1:0] x;
   logic [YW-1:0] y;

   // Out-of-grid moves are clamped by simply not taking them.
   always_comb begin
      nxt_x = x;
      nxt_y = y;
      if (en) begin
         case (decode_dir(up, down, left, right))
            DIR_UP:    if (y != YW'(GRID_H - 1)) nxt_y = y + YW'(1);
            DIR_DOWN:  if (y != '0)              nxt_y = y - YW'(1);
            DIR_LEFT:  if (x != '0)              nxt_x = x - XW'(1);
            DIR_RIGHT: if (x != XW'(GRID_W - 1)) nxt_x = x + XW'(1);
            default:   ;
         endcase
      end
      moved = (nxt_x != x) || (nxt_y != y);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= XW'(X0);
         y <= YW'(Y0);
      end else begin
         x <= nxt_x;
         y <= nxt_y;
      end
   end

endmodule

// File: rtl/planning.sv
// planning: robot and one obstacle sharing a grid, alternating turns.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   robot_turn            1: robot request honoured, 0: obstacle request
//   obs1_*                obstacle move request bits
//   robot_*               robot move request bits
//   error                 sticky collision flag; freezes both movers
//   rt_robot, rt_obs1     one-cycle pulse after the robot / obstacle moved
module planning
   import planning_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int OBS1_X0 = 3,
   parameter int OBS1_Y0 = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic robot_turn,
   input  logic obs1_up,
   input  logic obs1_down,
   input  logic obs1_left,
   input  logic obs1_right,
   input  logic robot_up,
   input  logic robot_down,
   input  logic robot_left,
   input  logic robot_right,
   output logic error,
   output logic rt_robot,
   output logic rt_obs1
);

   localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

   // The obstacle must start inside the grid and off the robot's home cell.
   if ((OBS1_X0 == 0 && OBS1_Y0 == 0) || OBS1_X0 < 0 || OBS1_Y0 < 0 ||
       OBS1_X0 >= GRID_W || OBS1_Y0 >= GRID_H) begin : g_bad_obs_start
      $error("planning: obstacle start position invalid");
   end

   logic [XW-1:0] r_nx, o_nx;
   logic [YW-1:0] r_ny, o_ny;
   logic          r_moved, o_moved;
   logic          collide;

   // Once error is set nothing moves, so the pair stays frozen in place.
   grid_mover #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .X0(0), .Y0(0), .XW(XW), .YW(YW)
   ) u_robot (
      .clk(clk), .rst_n(rst_n), .en(robot_turn && !error),
      .up(robot_up), .down(robot_down), .left(robot_left), .right(robot_right),
      .nxt_x(r_nx), .nxt_y(r_ny), .moved(r_moved)
   );

   grid_mover #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .X0(OBS1_X0), .Y0(OBS1_Y0), .XW(XW), .YW(YW)
   ) u_obs1 (
      .clk(clk), .rst_n(rst_n), .en(!robot_turn && !error),
      .up(obs1_up), .down(obs1_down), .left(obs1_left), .right(obs1_right),
      .nxt_x(o_nx), .nxt_y(o_ny), .moved(o_moved)
   );

   // Compared on next positions so the colliding move itself completes.
   assign collide = (r_nx == o_nx) && (r_ny == o_ny);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error    <= 1'b0;
         rt_robot <= 1'b0;
         rt_obs1  <= 1'b0;
      end else begin
         error    <= error || collide;
         rt_robot <= r_moved;
         rt_obs1  <= o_moved;
      end
   end

endmodule

// File: tb/tb_planning.sv
module tb_planning;

   localparam int GW = 8;
   localparam int GH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic robot_turn = 1'b0;
   logic obs1_up = 0, obs1_down = 0, obs1_left = 0, obs1_right = 0;
   logic robot_up = 0, robot_down = 0, robot_left = 0, robot_right = 0;
   logic error, rt_robot, rt_obs1;

   planning dut (
      .clk(clk), .rst_n(rst_n), .robot_turn(robot_turn),
      .obs1_up(obs1_up), .obs1_down(obs1_down), .obs1_left(obs1_left), .obs1_right(obs1_right),
      .robot_up(robot_up), .robot_down(robot_down), .robot_left(robot_left), .robot_right(robot_right),
      .error(error), .rt_robot(rt_robot), .rt_obs1(rt_obs1)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rx, ry, ox, oy;
      bit err, rtr, rto;
      string tag;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model state: plain integer coordinates.
   int mrx, mry, mox, moy;
   bit merr;

   // bits = {up, down, left, right}
   task automatic step(inout int x, inout int y, input bit [3:0] b);
      int nx, ny;
      if ($countones(b) != 1) return;
      nx = x; ny = y;
      if (b[3]) ny = ny + 1;
      if (b[2]) ny = ny - 1;
      if (b[1]) nx = nx - 1;
      if (b[0]) nx = nx + 1;
      if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
         x = nx; y = ny;
      end
   endtask

   task automatic push_exp(input bit rtr, input bit rto, input string tag);
      exp_t e;
      e.rx = mrx; e.ry = mry; e.ox = mox; e.oy = moy;
      e.err = merr; e.rtr = rtr; e.rto = rto; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      mrx = 0; mry = 0; mox = 3; moy = 3; merr = 0;
      push_exp(0, 0, tag);
   endtask

   task automatic cycle(input bit turn, input bit [3:0] rb, input bit [3:0] ob, input string tag);
      int prx, pry, pox, poy;
      @(negedge clk);
      rst_n = 1'b1;
      robot_turn = turn;
      {robot_up, robot_down, robot_left, robot_right} = rb;
      {obs1_up, obs1_down, obs1_left, obs1_right} = ob;
      prx = mrx; pry = mry; pox = mox; poy = moy;
      if (!merr) begin
         if (turn) step(mrx, mry, rb);
         else      step(mox, moy, ob);
         if (mrx == mox && mry == moy) merr = 1;
      end
      push_exp((mrx != prx) || (mry != pry), (mox != pox) || (moy != poy), tag);
   endtask

   // Monitor: compares one expectation per clock, 1 time unit after the edge.
   initial begin
      exp_t e;
      int arx, ary, aox, aoy;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            arx = int'(dut.u_robot.x); ary = int'(dut.u_robot.y);
            aox = int'(dut.u_obs1.x);  aoy = int'(dut.u_obs1.y);
            checks++;
            if (arx != e.rx || ary != e.ry || aox != e.ox || aoy != e.oy ||
                error !== e.err || rt_robot !== e.rtr || rt_obs1 !== e.rto) begin
               errors++;
               $display("FAIL %s: got robot=(%0d,%0d) obs=(%0d,%0d) err=%b rt_r=%b rt_o=%b, want robot=(%0d,%0d) obs=(%0d,%0d) err=%b rt_r=%b rt_o=%b",
                        e.tag, arx, ary, aox, aoy, error, rt_robot, rt_obs1,
                        e.rx, e.ry, e.ox, e.oy, e.err, e.rtr, e.rto);
            end
         end
      end
   end

   initial begin
      bit [3:0] rb, ob;
      // idle robot turn
      do_reset("reset");
      cycle(1, 4'b0000, 4'b0000, "idle1");
      cycle(1, 4'b0000, 4'b0000, "idle2");
      // obstacle right twice
      do_reset("reset2");
      cycle(0, 4'b0000, 4'b0001, "obs_right1");
      cycle(0, 4'b0000, 4'b0001, "obs_right2");
      // clamp at origin
      cycle(1, 4'b0010, 4'b0000, "clamp_left");
      cycle(1, 4'b0100, 4'b0000, "clamp_down");
      // multi-bit request ignored
      cycle(1, 4'b1001, 4'b0000, "multi_bit");
      // robot bits ignored on obstacle turn
      cycle(0, 4'b1000, 4'b0000, "wrong_turn");
      // drive robot into the obstacle at (3,3)
      do_reset("reset3");
      for (int i = 0; i < 3; i++) cycle(1, 4'b1000, 4'b0000, "up");
      for (int i = 0; i < 2; i++) cycle(1, 4'b0001, 4'b0000, "right");
      cycle(1, 4'b0001, 4'b0000, "collide");
      cycle(1, 4'b1000, 4'b0000, "frozen_r");
      cycle(0, 4'b0000, 4'b0010, "frozen_o");
      do_reset("reset_after_err");
      // top-edge clamp for the obstacle
      for (int i = 0; i < 5; i++) cycle(0, 4'b0000, 4'b1000, "obs_up_edge");
      // randomized
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0 || (merr && $urandom_range(0, 3) == 0)) begin
            do_reset("rand_reset");
         end else begin
            rb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            ob = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            cycle(1'($urandom), rb, ob, "random");
         end
      end
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
